// File: rtl/step_controller_if.sv
// -----------------------------------------------------------------------------
// step_controller_if
//   The CPU-side link between step_controller and the LiteCPU core.
//
//   Handshake: cpu_en is the core's clock enable. The core may assert
//   instr_done (with halt_in and pc describing the retiring instruction) only
//   in a cycle where cpu_en is 1. The controller treats instr_done with
//   cpu_en=0 as meaningless. cpu_en drops in the cycle after the retiring
//   instr_done, so an instruction is never cut short.
//
//   Signals:
//     cpu_en      controller -> core   clock enable
//     instr_done  core -> controller   instruction retires this cycle
//     halt_in     core -> controller   retiring instruction is HALT
//     pc          core -> controller   address of retiring instruction
//
//   Modports: master = controller side, slave = core side.
// -----------------------------------------------------------------------------
interface step_controller_if #(
   parameter int ADDR_W = 8
) ();
   logic              cpu_en;
   logic              instr_done;
   logic              halt_in;
   logic [ADDR_W-1:0] pc;

   modport master (output cpu_en, input instr_done, input halt_in, input pc);
   modport slave  (input cpu_en, output instr_done, output halt_in, output pc);
endinterface

// File: rtl/step_controller.sv
// -----------------------------------------------------------------------------
// step_controller
//   Run/single-step controller for the LiteCPU core. Consumes the debouncer's
//   step and run/stop press pulses and drives the CPU clock enable so the
//   core either free-runs or retires exactly one instruction per step press.
//   Step presses arriving during a step are queued in a saturating counter.
//
//   Optional feature (macro STEP_CTRL_BREAK_EN): breakpoint comparator that
//   stops free-run when the instruction at bp_addr retires. Without the macro
//   pc/bp_addr/bp_valid are ignored and bp_hit is tied low.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     step_in     step press pulse (one event per rising edge)
//     run_in      run/stop press pulse (one toggle per rising edge)
//     cpu         step_controller_if.master (cpu_en, instr_done, halt_in, pc)
//     bp_addr     breakpoint address
//     bp_valid    breakpoint armed
//     state       00 HALT, 01 STEP, 10 RUN (FSM state, also for debug)
//     pending     queued step requests
//     step_cnt    instructions retired since reset (wraps)
//     bp_hit      one-cycle pulse on breakpoint stop
// -----------------------------------------------------------------------------
module step_controller #(
   parameter int PEND_W = 3,
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 step_in,
   input  logic                 run_in,
   step_controller_if.master    cpu,
   input  logic [ADDR_W-1:0]    bp_addr,
   input  logic                 bp_valid,
   output logic [1:0]           state,
   output logic [PEND_W-1:0]    pending,
   output logic [CNT_W-1:0]     step_cnt,
   output logic                 bp_hit
);

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_STEP = 2'b01,
      ST_RUN  = 2'b10
   } state_e;

   state_e             state_q, state_d;
   logic [PEND_W-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0]   step_cnt_q;
   logic               run_req_q, run_req_d;
   logic               stop_req_q, stop_req_d;
   logic               bp_hit_q, bp_hit_d;
   logic               step_q, run_q;

   logic step_ev, run_ev, retire, bp_match;

   // Edge registers reset to 1 so a button held through reset release
   // does not produce a spurious event.
   assign step_ev = step_in & ~step_q;
   assign run_ev  = run_in  & ~run_q;
   assign retire  = cpu.instr_done & cpu.cpu_en;

`ifdef STEP_CTRL_BREAK_EN
   assign bp_match = bp_valid && (cpu.pc == bp_addr);
`else
   assign bp_match = 1'b0;
   logic unused_bp;
   assign unused_bp = ^{bp_addr, bp_valid, cpu.pc};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_HALT;
         pending_q  <= '0;
         step_cnt_q <= '0;
         run_req_q  <= 1'b0;
         stop_req_q <= 1'b0;
         bp_hit_q   <= 1'b0;
         step_q     <= 1'b1;
         run_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         run_req_q  <= run_req_d;
         stop_req_q <= stop_req_d;
         bp_hit_q   <= bp_hit_d;
         step_q     <= step_in;
         run_q      <= run_in;
         if (retire) step_cnt_q <= step_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      run_req_d  = run_req_q;
      stop_req_d = stop_req_q;
      bp_hit_d   = 1'b0;

      case (state_q)
         ST_HALT: begin
            if (run_ev) begin
               // run beats a simultaneous step; the step is discarded
               state_d    = ST_RUN;
               pending_d  = '0;
               run_req_d  = 1'b0;
               stop_req_d = 1'b0;
            end else if (step_ev || (pending_q != '0)) begin
               state_d = ST_STEP;
               // a fresh press is consumed directly; otherwise pop the queue
               if (!step_ev) pending_d = pending_q - 1'b1;
            end
         end
         ST_STEP: begin
            if (step_ev && (pending_q != '1)) pending_d = pending_q + 1'b1;
            if (run_ev) run_req_d = 1'b1;
            if (cpu.instr_done) begin
               state_d   = (run_req_q || run_ev) ? ST_RUN : ST_HALT;
               run_req_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (run_ev) stop_req_d = 1'b1;
            if (cpu.instr_done && bp_match) begin
               state_d    = ST_HALT;
               stop_req_d = 1'b0;
               bp_hit_d   = 1'b1;
            end else if (cpu.instr_done && (stop_req_q || run_ev)) begin
               state_d    = ST_HALT;
               stop_req_d = 1'b0;
            end
         end
         default: state_d = ST_HALT;
      endcase

      // HALT instruction overrides everything and flushes all requests
      if (retire && cpu.halt_in) begin
         state_d    = ST_HALT;
         pending_d  = '0;
         run_req_d  = 1'b0;
         stop_req_d = 1'b0;
         bp_hit_d   = 1'b0;
      end
   end

   assign cpu.cpu_en = (state_q != ST_HALT);
   assign state      = state_q;
   assign pending    = pending_q;
   assign step_cnt   = step_cnt_q;
   assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_step_controller.sv
module tb_step_controller;

   localparam int PEND_W = 3;
   localparam int CNT_W  = 16;
   localparam int ADDR_W = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              step_in, run_in, bp_valid, bp_hit;
   logic [ADDR_W-1:0] bp_addr;
   logic [1:0]        state;
   logic [PEND_W-1:0] pending;
   logic [CNT_W-1:0]  step_cnt;

   step_controller_if #(.ADDR_W(ADDR_W)) cpu_bus ();

   step_controller #(.PEND_W(PEND_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_in  (step_in),
      .run_in   (run_in),
      .cpu      (cpu_bus.master),
      .bp_addr  (bp_addr),
      .bp_valid (bp_valid),
      .state    (state),
      .pending  (pending),
      .step_cnt (step_cnt),
      .bp_hit   (bp_hit)
   );

   int total = 0;
   int bad   = 0;
   int en_cycles = 0;
   int exp_cnt = 0;
   logic [CNT_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      if (cpu_bus.cpu_en) en_cycles++;
   endtask

   task automatic step_pulse();
      step_in = 1'b1; tick();
      step_in = 1'b0; tick();
   endtask

   task automatic run_pulse();
      run_in = 1'b1; tick();
      run_in = 1'b0; tick();
   endtask

   task automatic retire(input logic [ADDR_W-1:0] pc_v, input logic halt_v);
      cpu_bus.instr_done = 1'b1;
      cpu_bus.halt_in    = halt_v;
      cpu_bus.pc         = pc_v;
      exp_cnt++;
      exp_q.push_back(CNT_W'(exp_cnt));
      tick();
      cpu_bus.instr_done = 1'b0;
      cpu_bus.halt_in    = 1'b0;
   endtask

   // scoreboard: every accepted retire must bump step_cnt by one
   always @(posedge clk) begin
      if (rst_n && cpu_bus.instr_done && cpu_bus.cpu_en) begin
         #1;
         if (exp_q.size() == 0) check("cnt_unexpected", 32'(step_cnt), 32'hFFFF_FFFF);
         else check("step_cnt", 32'(step_cnt), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      rst_n = 1'b0; step_in = 1'b0; run_in = 1'b0;
      bp_valid = 1'b0; bp_addr = '0;
      cpu_bus.instr_done = 1'b0; cpu_bus.halt_in = 1'b0; cpu_bus.pc = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_cpu_en", 32'(cpu_bus.cpu_en), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_step_cnt", 32'(step_cnt), 0);
      check("rst_bp_hit", 32'(bp_hit), 0);
      rst_n = 1'b1;
      tick(); tick();

      // 1: 2-cycle-wide step pulse, one instruction
      en_cycles = 0;
      step_in = 1'b1; tick();
      check("t1_state_step", 32'(state), 1);
      tick();
      step_in = 1'b0; tick();
      tick();
      retire(8'h00, 1'b0);
      check("t1_state_halt", 32'(state), 0);
      check("t1_en_cycles", 32'(en_cycles), 4);
      check("t1_pending", 32'(pending), 0);
      tick();
      check("t1_still_halt", 32'(state), 0);

      // 2: three queued steps
      step_pulse();
      repeat (3) step_pulse();
      check("t2_pending3", 32'(pending), 3);
      for (int i = 0; i < 4; i++) begin
         retire(8'h10, 1'b0);
         check("t2_gap_halt", 32'(state), 0);
         if (i < 3) begin
            tick();
            check("t2_restep", 32'(state), 1);
            check("t2_pending", 32'(pending), 32'(2 - i));
         end
      end
      tick();
      check("t2_end_state", 32'(state), 0);
      check("t2_end_cnt", 32'(step_cnt), 5);

      // 3: saturation at 7
      step_pulse();
      repeat (9) step_pulse();
      check("t3_sat", 32'(pending), 7);
      for (int i = 0; i < 8; i++) begin
         retire(8'h20, 1'b0);
         check("t3_gap_halt", 32'(state), 0);
         if (i < 7) begin
            tick();
            check("t3_pending", 32'(pending), 32'(6 - i));
         end
      end
      tick();
      check("t3_end_state", 32'(state), 0);
      check("t3_end_cnt", 32'(step_cnt), 13);

      // 4: run, steps ignored, stop only at instruction boundary
      run_pulse();
      check("t4_run", 32'(state), 2);
      step_pulse();
      step_pulse();
      check("t4_no_queue", 32'(pending), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         retire(8'h30, 1'b0);
         check("t4_running", 32'(state), 2);
      end
      run_pulse();
      check("t4_no_midstop", 32'(state), 2);
      check("t4_en_mid", 32'(cpu_bus.cpu_en), 1);
      tick();
      retire(8'h31, 1'b0);
      check("t4_stopped", 32'(state), 0);
      check("t4_en_off", 32'(cpu_bus.cpu_en), 0);

      // 5: HALT instruction during RUN flushes queued steps
      step_pulse();
      step_pulse();
      step_pulse();
      check("t5_pending2", 32'(pending), 2);
      run_pulse();
      retire(8'h40, 1'b0);
      check("t5_run", 32'(state), 2);
      check("t5_pend_kept", 32'(pending), 2);
      tick();
      retire(8'h41, 1'b1);
      check("t5_halt", 32'(state), 0);
      check("t5_flush", 32'(pending), 0);
      check("t5_en_off", 32'(cpu_bus.cpu_en), 0);
      tick();
      check("t5_stay_halt", 32'(state), 0);

      // 6: simultaneous run+step in HALT -> run wins
      run_in = 1'b1; step_in = 1'b1; tick();
      check("t6_run_wins", 32'(state), 2);
      check("t6_no_pend", 32'(pending), 0);
      run_in = 1'b0; step_in = 1'b0; tick();
      run_pulse();
      retire(8'h50, 1'b0);
      check("t6_halt", 32'(state), 0);

      // 7: breakpoint
      bp_valid = 1'b1; bp_addr = 8'h2A;
      run_pulse();
      retire(8'h28, 1'b0);
      check("t7_run_28", 32'(state), 2);
      check("t7_nohit_28", 32'(bp_hit), 0);
      retire(8'h29, 1'b0);
      check("t7_run_29", 32'(state), 2);
      retire(8'h2A, 1'b0);
`ifdef STEP_CTRL_BREAK_EN
      check("t7_bp_state", 32'(state), 0);
      check("t7_bp_hit", 32'(bp_hit), 1);
      tick();
      check("t7_bp_pulse", 32'(bp_hit), 0);
      check("t7_bp_stay", 32'(state), 0);
`else
      check("t7_nobp_state", 32'(state), 2);
      check("t7_nobp_hit", 32'(bp_hit), 0);
      run_pulse();
      retire(8'h2B, 1'b0);
      check("t7_nobp_stop", 32'(state), 0);
`endif

      tick(); tick();
      check("sb_empty", 32'(exp_q.size()), 0);
      check("final_cnt", 32'(step_cnt), 32'(exp_cnt));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
